// File: rtl/group_delay_calc.sv
// group_delay_calc
//   Group delay from a swept, wrapped phase stream: tau = -(dphi * scale),
//   with dphi the wrapped difference of consecutive phase samples and
//   scale = 1/(2*pi*df). Phase full scale 2^(PW-1) equals pi rad.
//
//   Build option: define GROUP_DELAY_AVG_EN to average each delta with the
//   previous one (floor), except the first delta of a sweep.
//
// Ports
//   clk, rst_n            clock (rising), asynchronous active-low reset
//   in_valid/in_ready     phase sample handshake
//   in_phase [PW]         signed wrapped phase
//   in_first, in_last     sweep boundaries
//   scale [SW]            unsigned scale, sampled with each accepted sample
//   out_valid/out_ready   result handshake
//   out_tau [PW+SW+1]     signed group delay
//   out_last              result of the in_last sample
//   out_idx [16]          result index within the sweep
module group_delay_calc #(
    parameter int PW = 16,
    parameter int SW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PW-1:0]        in_phase,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [SW-1:0]        scale,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PW+SW:0]       out_tau,
    output logic                 out_last,
    output logic [15:0]          out_idx
);
    localparam int TW     = PW + SW + 1;
    localparam int STAGES = 2;

    typedef enum logic {IDLE, PRIMED} state_t;

    state_t              state;
    logic [PW-1:0]       prev_phase;
    logic [15:0]         idx_cnt;
    logic [STAGES:1]     vld_pipe;

    logic [PW-1:0]       s1_delta;
    logic [SW-1:0]       s1_scale;
    logic                s1_last;
    logic [15:0]         s1_idx;

    logic                advance, accept, start, produce;
    logic [PW-1:0]       raw_delta, use_delta;
    logic signed [TW-1:0] prod;

    // Whole pipeline advances together; only a held output blocks it.
    assign advance   = !(vld_pipe[STAGES] && !out_ready);
    assign in_ready  = advance;
    assign out_valid = vld_pipe[STAGES];
    assign accept    = in_valid && advance;
    assign start     = (state == IDLE) || in_first;
    assign produce   = accept && !start;

    // Modulo-2^PW subtraction lands the delta in [-pi, pi) by itself.
    assign raw_delta = in_phase - prev_phase;

`ifdef GROUP_DELAY_AVG_EN
    logic [PW-1:0] prev_delta;
    logic          prev_delta_vld;
    logic [PW-1:0] avg_delta;

    // floor((a+b)/2) without a wider adder: (a>>>1)+(b>>>1)+(a0&b0).
    assign avg_delta = $unsigned($signed(raw_delta) >>> 1)
                     + $unsigned($signed(prev_delta) >>> 1)
                     + {{(PW-1){1'b0}}, raw_delta[0] & prev_delta[0]};
    assign use_delta = prev_delta_vld ? avg_delta : raw_delta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_delta     <= '0;
            prev_delta_vld <= 1'b0;
        end else if (accept) begin
            if (start) begin
                prev_delta_vld <= 1'b0;
            end else begin
                prev_delta     <= raw_delta;
                prev_delta_vld <= 1'b1;
            end
        end
    end
`else
    assign use_delta = raw_delta;
`endif

    // Signed delta times zero-extended scale; -2^(PW-1)*(2^SW-1) fits in TW.
    assign prod = $signed({{(SW+1){s1_delta[PW-1]}}, s1_delta})
                * $signed({{(PW+1){1'b0}}, s1_scale});

    // Sweep FSM: tracks whether a previous phase is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev_phase <= '0;
            idx_cnt    <= '0;
        end else if (accept) begin
            prev_phase <= in_phase;
            idx_cnt    <= start ? 16'd0 : idx_cnt + 16'd1;
            state      <= in_last ? IDLE : PRIMED;
        end
    end

    // Stage 1 holds delta/scale/last/idx; stage 2 is the output register.
    // The index rides along so results in flight keep it across in_first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_delta <= '0;
            s1_scale <= '0;
            s1_last  <= 1'b0;
            s1_idx   <= '0;
            out_tau  <= '0;
            out_last <= 1'b0;
            out_idx  <= '0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[1], produce};
            if (produce) begin
                s1_delta <= use_delta;
                s1_scale <= scale;
                s1_last  <= in_last;
                s1_idx   <= idx_cnt;
            end
            if (vld_pipe[1]) begin
                out_tau  <= $unsigned(-prod);
                out_last <= s1_last;
                out_idx  <= s1_idx;
            end
        end
    end

endmodule

// File: tb/tb_group_delay_calc.sv
module tb_group_delay_calc;
    localparam int PW = 16;
    localparam int SW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PW-1:0]     in_phase = '0;
    logic              in_first = 1'b0;
    logic              in_last = 1'b0;
    logic [SW-1:0]     scale = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [PW+SW:0]    out_tau;
    logic              out_last;
    logic [15:0]       out_idx;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        longint tau;
        longint idx;
        longint last;
    } res_t;

    res_t got_q[$];
    res_t exp_q[$];
    bit   saw_not_ready;

    group_delay_calc #(.PW(PW), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_phase(in_phase), .in_first(in_first), .in_last(in_last),
        .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tau(out_tau), .out_last(out_last), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so a handshake seen at negedge
    // completes on the following posedge exactly once.
    always @(negedge clk) begin
        if (out_valid && out_ready)
            got_q.push_back('{tau: longint'($signed(out_tau)),
                              idx: longint'(out_idx), last: longint'(out_last)});
        if (!in_ready) saw_not_ready = 1'b1;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_res(input longint tau, input longint idx, input longint last);
        exp_q.push_back('{tau: tau, idx: idx, last: last});
    endtask

    task automatic compare_q(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_tau%0d", tag, i),  got_q[i].tau,  exp_q[i].tau);
            chk($sformatf("%s_idx%0d", tag, i),  got_q[i].idx,  exp_q[i].idx);
            chk($sformatf("%s_last%0d", tag, i), got_q[i].last, exp_q[i].last);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input int ph, input bit f, input bit l, input int sc);
        int n;
        in_valid = 1'b1;
        in_phase = ph[PW-1:0];
        in_first = f;
        in_last  = l;
        scale    = sc[SW-1:0];
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready",  longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_tau",   longint'(out_tau), 0);
        chk("rst_out_last",  longint'(out_last), 0);
        chk("rst_out_idx",   longint'(out_idx), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic sweep with latency check
        send(0, 1, 0, 100);
        send(1000, 0, 0, 100);
        @(negedge clk);
        chk("lat_s1_valid", longint'(out_valid), 0);
        @(negedge clk);
        chk("lat_s2_valid", longint'(out_valid), 1);
        chk("lat_s2_tau",   longint'($signed(out_tau)), -100000);
        @(posedge clk);
        #1;
        send(3000, 0, 1, 100);
        drain();
        expect_res(-100000, 0, 0);
`ifdef GROUP_DELAY_AVG_EN
        expect_res(-150000, 1, 1);
`else
        expect_res(-200000, 1, 1);
`endif
        compare_q("basic");

        // Phase wrap: -32000 - 32000 wraps to +1536
        send(32000, 1, 0, 100);
        send(-32000, 0, 1, 100);
        drain();
        expect_res(-153600, 0, 1);
        compare_q("wrap");

        // Backpressure during a 4-sample stream
        saw_not_ready = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                send(0, 1, 0, 2);
                send(100, 0, 0, 2);
                send(300, 0, 0, 2);
                send(600, 0, 1, 2);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_in_ready_dropped", longint'(saw_not_ready), 1);
        expect_res(-200, 0, 0);
`ifdef GROUP_DELAY_AVG_EN
        expect_res(-300, 1, 0);
        expect_res(-500, 2, 1);
`else
        expect_res(-400, 1, 0);
        expect_res(-600, 2, 1);
`endif
        compare_q("bp");

        // Reset while a result sits in stage 1
        send(0, 1, 0, 100);
        send(1000, 0, 0, 100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_in_ready",  longint'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drain();
        chk("post_rst_no_stale", got_q.size(), 0);
        send(500, 0, 0, 100);
        send(800, 0, 1, 100);
        drain();
        expect_res(-30000, 0, 1);
        compare_q("after_rst");

        // in_first mid-sweep restarts the index
        send(0, 1, 0, 3);
        send(500, 0, 0, 3);
        send(0, 1, 0, 3);
        send(200, 0, 1, 3);
        drain();
        expect_res(-1500, 0, 0);
        expect_res(-600, 0, 1);
        compare_q("restart");

        // Unit scale, averaging distinguishes the second result
        send(0, 1, 0, 1);
        send(1000, 0, 0, 1);
        send(3000, 0, 1, 1);
        drain();
        expect_res(-1000, 0, 0);
`ifdef GROUP_DELAY_AVG_EN
        expect_res(-1500, 1, 1);
`else
        expect_res(-2000, 1, 1);
`endif
        compare_q("unit");

        // Extreme product: delta -2^15 with max scale
        send(0, 1, 0, 65535);
        send(-32768, 0, 1, 65535);
        drain();
        expect_res(64'sd2147450880, 0, 1);
        compare_q("extreme");

        // first+last together yields nothing and leaves FSM idle
        send(123, 1, 1, 10);
        send(200, 0, 1, 10);
        drain();
        compare_q("first_last");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
